// File: rtl/mem_bank_if.sv
// mem_bank_if: command/response bus between the memory controller or BIST mux
// (master) and the banked SRAM array (slave). Chip selects and output enables
// are active low, one bit per bank.
interface mem_bank_if #(
  parameter int BANKS  = 64,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) ();
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ce;
  logic              mem_web;
  logic [BANKS-1:0]  mem_csb;
  logic [BANKS-1:0]  mem_oeb;
  logic [DATA_W-1:0] mem_idata;
  logic [DATA_W-1:0] mem_odata;
  logic              mem_odata_valid;
  logic              sel_err;

  modport master (
    output mem_addr, mem_ce, mem_web, mem_csb, mem_oeb, mem_idata,
    input  mem_odata, mem_odata_valid, sel_err
  );

  modport slave (
    input  mem_addr, mem_ce, mem_web, mem_csb, mem_oeb, mem_idata,
    output mem_odata, mem_odata_valid, sel_err
  );
endinterface

// File: rtl/mem_bank_array.sv
// mem_bank_array: behavioural banked SRAM responder.
// BANKS x 2^ADDR_W x DATA_W storage behind one-hot active-low chip selects.
// Writes complete on the command edge; reads travel through a READ_LAT-deep
// pipeline (1..3) whose last stage is gated by the per-bank output enable.
// Commands selecting more than one bank are dropped and flagged on sel_err.
// Optional feature: define MEM_BANK_STATS_EN to add saturating write, read
// and select-error counters (wr_cnt, rd_cnt, err_cnt).
module mem_bank_array #(
  parameter int BANKS    = 64,
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic            clk,
  input  logic            rstn,
  mem_bank_if.slave       bus
`ifdef MEM_BANK_STATS_EN
  ,
  output logic [15:0]     wr_cnt,
  output logic [15:0]     rd_cnt,
  output logic [7:0]      err_cnt
`endif
);

  localparam int BSEL_W = $clog2(BANKS);
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef struct packed {
    logic              valid;
    logic [BSEL_W-1:0] bank;
    logic [DATA_W-1:0] data;
  } rd_stage_t;

  if (READ_LAT < 1 || READ_LAT > 3) begin : g_bad_read_lat
    $error("mem_bank_array: READ_LAT must be in 1..3");
  end

  logic [DATA_W-1:0] mem [BANKS][DEPTH];

  logic [BANKS-1:0]  sel;
  logic              any_sel;
  logic              multi_sel;
  logic [BSEL_W-1:0] bank;
  logic              cmd_ok;
  logic              wr_en;
  logic              rd_en;
  logic              err_hit;
  logic              out_fire;
  rd_stage_t         launch;
  rd_stage_t         out_stage;

  // Command decode: find the selected bank and classify the command.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    sel       = ~bus.mem_csb;
    any_sel   = |sel;
    multi_sel = |(sel & (sel - BANKS'(1)));
    bank      = '0;
    for (int i = 0; i < BANKS; i++) begin
      if (sel[i]) bank = BSEL_W'(i);
    end
    cmd_ok  = bus.mem_ce & any_sel & ~multi_sel;
    wr_en   = cmd_ok & ~bus.mem_web;
    rd_en   = cmd_ok & bus.mem_web;
    err_hit = bus.mem_ce & multi_sel;
  end

  // Array write port; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    // NOTE: the storage has no reset on purpose; contents stay undefined
    // until written, exactly like the SRAM macro this stands in for.
    if (rstn && wr_en) mem[bank][bus.mem_addr] <= bus.mem_idata;
  end

  // Stage-1 read capture: what a read command loads on its command edge.
  always_comb begin
    launch.valid = rd_en;
    launch.bank  = bank;
    launch.data  = mem[bank][bus.mem_addr];
  end

  // Intermediate pipeline stages; with READ_LAT=1 the command edge is
  // itself the output-stage edge.
  if (READ_LAT <= 1) begin : g_lat1
    assign out_stage = launch;
  end else begin : g_latn
    rd_stage_t pipe [READ_LAT-1];

    // Shift read stages one per cycle, clearing them on reset.
    always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every stage samples the previous
      // stage's old value, independent of statement order.
      if (!rstn) begin
        for (int i = 0; i < READ_LAT - 1; i++) pipe[i] <= '0;
      end else begin
        pipe[0] <= launch;
        for (int i = 1; i < READ_LAT - 1; i++) pipe[i] <= pipe[i-1];
      end
    end

    assign out_stage = pipe[READ_LAT-2];
  end

  assign out_fire = out_stage.valid & ~bus.mem_oeb[out_stage.bank];

  // Output stage: registered data/valid gated by the bank's output enable,
  // plus the one-cycle select-error flag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      bus.mem_odata       <= '0;
      bus.mem_odata_valid <= 1'b0;
      bus.sel_err         <= 1'b0;
    end else begin
      bus.sel_err         <= err_hit;
      bus.mem_odata_valid <= out_fire;
      if (out_fire) begin
        bus.mem_odata <= out_stage.data;
      end else if (out_stage.valid) begin
        bus.mem_odata <= '0;
      end
    end
  end

`ifdef MEM_BANK_STATS_EN
  // Saturating activity counters: legal writes, delivered reads, select errors.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      err_cnt <= '0;
    end else begin
      if (wr_en && wr_cnt != '1)     wr_cnt  <= wr_cnt + 16'd1;
      if (out_fire && rd_cnt != '1)  rd_cnt  <= rd_cnt + 16'd1;
      if (err_hit && err_cnt != '1)  err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_bank_array.sv
// tb_mem_bank_array: self-checking bench for mem_bank_array (READ_LAT=3).
// A cycle-level reference model (plain arrays plus a queue of pending reads
// with due cycles) predicts every output after every clock edge. Directed
// scenarios are followed by a randomized $urandom phase.
// Define MEM_BANK_STATS_EN to also check the statistics counters.
module tb_mem_bank_array;

  localparam int BANKS  = 64;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int LAT    = 3;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  mem_bank_if #(.BANKS(BANKS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef MEM_BANK_STATS_EN
  logic [15:0] wr_cnt;
  logic [15:0] rd_cnt;
  logic [7:0]  err_cnt;
`endif

  mem_bank_array #(
    .BANKS(BANKS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(LAT)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
`ifdef MEM_BANK_STATS_EN
    ,
    .wr_cnt  (wr_cnt),
    .rd_cnt  (rd_cnt),
    .err_cnt (err_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    int          bank;
    logic [7:0]  data;
  } rd_t;

  logic [7:0] mdl [BANKS][2**ADDR_W];
  rd_t        pending [$];
  int         cyc = 0;
  logic [7:0] exp_odata;
  logic       exp_valid;
  logic       exp_err;
  int         m_wr, m_rd, m_err;

  function automatic int sat(input int v, input int max);
    return (v >= max) ? max : v + 1;
  endfunction

  // Predict the effect of the coming clock edge from the inputs now driven.
  task automatic model_edge();
    int  n;
    int  b;
    rd_t r;
    if (!rstn) begin
      exp_odata = '0;
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      pending.delete();
      m_wr = 0; m_rd = 0; m_err = 0;
    end else begin
      n = $countones(~bus.mem_csb);
      b = -1;
      for (int i = 0; i < BANKS; i++) if (!bus.mem_csb[i]) b = i;
      exp_err = bus.mem_ce && (n > 1);
      if (bus.mem_ce && n == 1) begin
        if (!bus.mem_web) begin
          mdl[b][bus.mem_addr] = bus.mem_idata;
          m_wr = sat(m_wr, 65535);
        end else begin
          r.due  = cyc + LAT - 1;
          r.bank = b;
          r.data = mdl[b][bus.mem_addr];
          pending.push_back(r);
        end
      end
      exp_valid = 1'b0;
      if (pending.size() > 0 && pending[0].due == cyc) begin
        r = pending.pop_front();
        if (!bus.mem_oeb[r.bank]) begin
          exp_odata = r.data;
          exp_valid = 1'b1;
        end else begin
          exp_odata = '0;
        end
      end
      if (exp_valid) m_rd  = sat(m_rd, 65535);
      if (exp_err)   m_err = sat(m_err, 255);
    end
    cyc++;
  endtask

  // One clock: model, edge, then compare all outputs 1 ns after the edge.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("odata", {24'd0, bus.mem_odata}, {24'd0, exp_odata});
    check("odata_valid", {31'd0, bus.mem_odata_valid}, {31'd0, exp_valid});
    check("sel_err", {31'd0, bus.sel_err}, {31'd0, exp_err});
`ifdef MEM_BANK_STATS_EN
    check("wr_cnt", {16'd0, wr_cnt}, m_wr);
    check("rd_cnt", {16'd0, rd_cnt}, m_rd);
    check("err_cnt", {24'd0, err_cnt}, m_err);
`endif
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic logic [BANKS-1:0] csb_of(input int b);
    logic [BANKS-1:0] one;
    one = '0;
    one[b] = 1'b1;
    return ~one;
  endfunction

  task automatic idle();
    bus.mem_ce    = 1'b0;
    bus.mem_web   = 1'b1;
    bus.mem_csb   = '1;
    bus.mem_addr  = '0;
    bus.mem_idata = '0;
  endtask

  task automatic wr(input int b, input int a, input logic [7:0] d);
    bus.mem_ce = 1'b1; bus.mem_web = 1'b0; bus.mem_csb = csb_of(b);
    bus.mem_addr = ADDR_W'(a); bus.mem_idata = d;
    step();
  endtask

  task automatic rd(input int b, input int a);
    bus.mem_ce = 1'b1; bus.mem_web = 1'b1; bus.mem_csb = csb_of(b);
    bus.mem_addr = ADDR_W'(a); bus.mem_idata = '0;
    step();
  endtask

  task automatic nop(input int n);
    idle();
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic bad_sel(input int b0, input int b1, input logic [7:0] d);
    bus.mem_ce = 1'b1; bus.mem_web = 1'b0;
    bus.mem_csb = csb_of(b0) & csb_of(b1);
    bus.mem_addr = ADDR_W'(3); bus.mem_idata = d;
    step();
  endtask

  initial begin
    int r, a0, b0, b1;
    logic [7:0] d;

    idle();
    bus.mem_oeb = '0;
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("reset_odata", {24'd0, bus.mem_odata}, 32'd0);
    check("reset_valid", {31'd0, bus.mem_odata_valid}, 32'd0);
    rstn = 1'b1;

    // 1: write then read bank 0 addr 0.
    wr(0, 0, 8'hA5);
    rd(0, 0);
    nop(LAT - 1);
    check("t1_valid", {31'd0, bus.mem_odata_valid}, 32'd1);
    check("t1_data", {24'd0, bus.mem_odata}, 32'hA5);
    nop(1);
    check("t1_valid_pulse", {31'd0, bus.mem_odata_valid}, 32'd0);

    // Prefill addresses 0..7 of every bank so later reads are defined.
    for (int b = 0; b < BANKS; b++)
      for (int a = 0; a < 8; a++) wr(b, a, 8'($urandom_range(1, 255)));

    // 2: extreme bank/address, back-to-back reads.
    wr(63, 'h3FF, 8'h5A);
    wr(1, 'h3FF, 8'h3C);
    rd(63, 'h3FF);
    rd(1, 'h3FF);
    nop(LAT - 2);
    check("t2_first", {24'd0, bus.mem_odata}, 32'h5A);
    check("t2_first_valid", {31'd0, bus.mem_odata_valid}, 32'd1);
    nop(1);
    check("t2_second", {24'd0, bus.mem_odata}, 32'h3C);
    check("t2_second_valid", {31'd0, bus.mem_odata_valid}, 32'd1);

    // 3: double select write is dropped and flagged.
    bad_sel(2, 5, 8'hFF);
    check("t3_sel_err", {31'd0, bus.sel_err}, 32'd1);
    nop(1);
    check("t3_sel_err_pulse", {31'd0, bus.sel_err}, 32'd0);
    rd(2, 3);
    rd(5, 3);
    nop(LAT);

    // 4: output enable high on bank 7 drops the read and zeroes odata.
    wr(7, 'h10, 8'h77);
    bus.mem_oeb = csb_of(7) ^ '1;
    rd(7, 'h10);
    nop(LAT - 1);
    check("t4_valid", {31'd0, bus.mem_odata_valid}, 32'd0);
    check("t4_data", {24'd0, bus.mem_odata}, 32'd0);
    bus.mem_oeb = '0;

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 2500; i++) begin
      r  = $urandom_range(0, 9);
      b0 = $urandom_range(0, BANKS - 1);
      a0 = $urandom_range(0, 7);
      d  = 8'($urandom);
      rstn = ($urandom_range(0, 199) != 0);
      bus.mem_oeb   = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : '0;
      bus.mem_ce    = (r != 9);
      bus.mem_web   = $urandom_range(0, 1) != 0;
      bus.mem_addr  = ADDR_W'(a0);
      bus.mem_idata = d;
      if (r == 0) begin
        bus.mem_csb = '1;
      end else if (r == 1) begin
        b1 = (b0 + 1 + $urandom_range(0, BANKS - 2)) % BANKS;
        bus.mem_csb = csb_of(b0) & csb_of(b1);
      end else begin
        bus.mem_csb = csb_of(b0);
      end
      step();
    end
    rstn = 1'b1;
    bus.mem_oeb = '0;
    nop(LAT);

    // 5: reset right after a read launch kills the in-flight read.
    rd(0, 0);
    idle();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    for (int i = 0; i < LAT + 1; i++) begin
      step();
      check("t5_no_valid", {31'd0, bus.mem_odata_valid}, 32'd0);
      check("t5_data_zero", {24'd0, bus.mem_odata}, 32'd0);
    end

    // 6: counter scenario, then select-error saturation.
    wr(10, 1, 8'h11);
    wr(11, 2, 8'h22);
    wr(12, 3, 8'h33);
    rd(10, 1);
    rd(11, 2);
    bad_sel(20, 40, 8'h00);
    nop(LAT);
`ifdef MEM_BANK_STATS_EN
    check("t6_wr_cnt", {16'd0, wr_cnt}, 32'd3);
    check("t6_rd_cnt", {16'd0, rd_cnt}, 32'd2);
    check("t6_err_cnt", {24'd0, err_cnt}, 32'd1);
`endif
    for (int i = 0; i < 300; i++) bad_sel(i % BANKS, (i + 7) % BANKS, 8'($urandom));
    nop(2);
`ifdef MEM_BANK_STATS_EN
    check("t6_err_sat", {24'd0, err_cnt}, 32'hFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
